prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named Clk and Reset.
REQ-002 Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Reset  input  1  asynchronous active-low reset; 0 forces the reset state immediately.
REQ-004 Start  input  1  single-cycle request to begin a new program load.
REQ-005 In_Valid  input  1  In_Data holds a valid byte.
REQ-006 In_Data  input  8  program byte stream; high byte of each word first.
REQ-007 In_Ready  output  1  loader accepts a byte this cycle.
REQ-008 IM_Wr  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 IM_Addr  output  7  instruction-memory word address, same width as the processor PC.
REQ-010 IM_Data  output  16  instruction word being written.
REQ-011 CPU_Reset  output  1  active-low reset to the processor; 0 holds it in reset.
REQ-012 Done  output  1  load completed with a halt word.
REQ-013 Error  output  1  128 words written without a halt word.
REQ-014 Count  output  8  number of words written in the current load, range 0..128.

Function
REQ-015 The state machine SHALL have the states IDLE, HI, LO, WRITE, DONE and ERR.
REQ-016 In IDLE: In_Ready=0, CPU_Reset=0. Start=1 moves to HI.
REQ-017 Entering HI from IDLE, DONE or ERR SHALL clear the address and Count to 0 and drive CPU_Reset=0.
REQ-018 In HI: In_Ready=1. A handshake (In_Valid & In_Ready) on a rising edge captures In_Data into word[15:8] and moves to LO. With no handshake, the state holds.
REQ-019 In LO: In_Ready=1. A handshake captures In_Data into word[7:0] and moves to WRITE.
REQ-020 In WRITE: In_Ready=0 and IM_Wr=1 for exactly one cycle, with IM_Addr = current address and IM_Data = assembled word. On the next edge the address and Count increment by 1.
REQ-021 WRITE SHALL go to DONE if the word equals 16'h5000 (halt); the halt word itself is written.
REQ-022 Otherwise, WRITE SHALL go to ERR if the address was 127, and to HI in all other cases.
REQ-023 The address SHALL never wrap silently; after a write at address 127 the only exits are DONE or ERR. Count reads 128 in that case.
REQ-024 In DONE: Done=1, CPU_Reset=1 (processor released), In_Ready=0. Start=1 restarts via HI.
REQ-025 In ERR: Error=1, CPU_Reset=0, In_Ready=0. Start=1 restarts via HI.
REQ-026 Start SHALL be ignored in HI, LO and WRITE; a load in progress is never aborted by Start.
REQ-027 IM_Wr SHALL be 0 in every state except WRITE. IM_Addr and IM_Data hold their last values outside WRITE.
REQ-028 Done, Error, In_Ready and CPU_Reset SHALL be decoded from the state only, as Moore outputs with no combinational path from the inputs.
REQ-029 Throughput: at most one word per 3 cycles (HI, LO, WRITE) with In_Valid held at 1.

Reset
REQ-030 While Reset=0, and asynchronously upon assertion: state=IDLE, IM_Addr=0, IM_Data=0, Count=0, IM_Wr=0, In_Ready=0, Done=0, Error=0, CPU_Reset=0.
REQ-031 Reset asserted mid-load SHALL discard any partial word with no further IM_Wr. After release the loader stays in IDLE until Start.
REQ-032 Reset release SHALL take effect on the first rising Clk edge after Reset rises.

Verification
REQ-033 Reset=0, then Reset=1 with no Start -> IDLE held, CPU_Reset=0, IM_Wr never 1, Count=0.
REQ-034 Start, then bytes 12,34,56,78,50,00 with In_Valid=1 continuously -> writes 1234@0, 5678@1, 5000@2, one IM_Wr each, 3 cycles apart; then Done=1, CPU_Reset=1, Count=3.
REQ-035 In_Valid toggled 1/0 each cycle while streaming 1 word + halt -> bytes accepted only when In_Valid=1; data 16'hA00F@0 and 16'h5000@1 are unchanged.
REQ-036 Start, then 128 non-halt words (0001..0080) -> last write at address 127 = 0080; ERR, Error=1, CPU_Reset=0, Count=128, no 129th IM_Wr.
REQ-037 Reset=0 pulsed in LO after high byte 50 -> no IM_Wr, IDLE; a new Start with 5000 writes address 0.
REQ-038 In DONE, Start -> CPU_Reset drops to 0 the next cycle, Count=0, the next word lands at address 0; a Start pulsed during LO has no effect.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: assembles a byte stream into 16-bit words, writes them into
// instruction memory and holds the processor in reset until a halt word lands.
module prog_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  In_Valid,
  input  logic [DATA_W-1:0]     In_Data,
  output logic                  In_Ready,
  output logic                  IM_Wr,
  output logic [ADDR_W-1:0]     IM_Addr,
  output logic [2*DATA_W-1:0]   IM_Data,
  output logic                  CPU_Reset,
  output logic                  Done,
  output logic                  Error,
  output logic [ADDR_W:0]       Count
);

  localparam logic [2*DATA_W-1:0] HALT_WORD = 16'h5000;
  localparam logic [ADDR_W:0]     LAST_ADDR = (ADDR_W+1)'((1 << ADDR_W) - 1);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE, ERR} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   hi_byte;
  logic                restart;

  // A new load may only be launched from a resting state.
  assign restart = Start && (state == IDLE || state == DONE || state == ERR);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start)    state_nxt = HI;
      HI:      if (In_Valid) state_nxt = LO;
      LO:      if (In_Valid) state_nxt = WRITE;
      WRITE: begin
        if (IM_Data == HALT_WORD)  state_nxt = DONE;
        else if (Count == LAST_ADDR) state_nxt = ERR;
        else                       state_nxt = HI;
      end
      DONE:    if (Start)    state_nxt = HI;
      ERR:     if (Start)    state_nxt = HI;
      default:               state_nxt = IDLE;
    endcase
  end

  // The write address always equals the number of words already written,
  // so Count doubles as the address counter; IM_Addr/IM_Data latch per word.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hi_byte <= '0;
      IM_Addr <= '0;
      IM_Data <= '0;
      Count   <= '0;
    end else begin
      if (state == HI && In_Valid) hi_byte <= In_Data;
      if (state == LO && In_Valid) begin
        IM_Data <= {hi_byte, In_Data};
        IM_Addr <= Count[ADDR_W-1:0];
      end
      if (restart)               Count <= '0;
      else if (state == WRITE)   Count <= Count + 1'b1;
    end
  end

  assign In_Ready  = (state == HI) || (state == LO);
  assign IM_Wr     = (state == WRITE);
  assign Done      = (state == DONE);
  assign Error     = (state == ERR);
  assign CPU_Reset = (state == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: drives byte streams and compares every
// instruction-memory write and the final status against a word-level model.
module tb_prog_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        In_Valid = 1'b0;
  logic [7:0]  In_Data = 8'h00;
  logic        In_Ready, IM_Wr, CPU_Reset, Done, Error;
  logic [6:0]  IM_Addr;
  logic [15:0] IM_Data;
  logic [7:0]  Count;

  prog_loader dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .In_Valid(In_Valid),
    .In_Data(In_Data), .In_Ready(In_Ready), .IM_Wr(IM_Wr), .IM_Addr(IM_Addr),
    .IM_Data(IM_Data), .CPU_Reset(CPU_Reset), .Done(Done), .Error(Error),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic tog = 1'b0;

  logic [6:0]  oa[$];
  logic [15:0] od[$];
  int          oc[$];

  logic [15:0] words[$];
  logic [6:0]  ea[$];
  logic [15:0] ed[$];
  bit          exp_done, exp_err;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (IM_Wr) begin
      oa.push_back(IM_Addr);
      od.push_back(IM_Data);
      oc.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: valid always, 1: valid toggles each cycle, 2: random valid
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit hs = 0;
    int budget = 200;
    while (!hs && budget > 0) begin
      @(negedge Clk);
      case (mode)
        0: In_Valid = 1'b1;
        1: begin tog = ~tog; In_Valid = tog; end
        default: In_Valid = ($urandom_range(0, 99) < 60);
      endcase
      In_Data = In_Valid ? b : 8'($urandom);
      #1;
      hs = In_Valid && In_Ready;
      @(posedge Clk);
      budget--;
    end
    if (!hs) chk("byte_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_word(input logic [15:0] w, input int mode);
    send_byte(w[15:8], mode);
    send_byte(w[7:0], mode);
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    In_Valid = 1'b0;
    Start = 1'b1;
    oa.delete(); od.delete(); oc.delete();
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(oa.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < oa.size(); i++) begin
      chk({tag, "_addr"}, 32'(oa[i]), 32'(ea[i]));
      chk({tag, "_data"}, 32'(od[i]), 32'(ed[i]));
    end
  endtask

  // Model: word i goes to address i; stop after the halt word or 128 words.
  task automatic run_load(input string tag, input int mode);
    ea.delete(); ed.delete();
    exp_done = 0;
    for (int i = 0; i < words.size(); i++) begin
      if (ea.size() == 128) break;
      ea.push_back(7'(i));
      ed.push_back(words[i]);
      if (words[i] == 16'h5000) begin
        exp_done = 1;
        break;
      end
    end
    exp_err = !exp_done && (ea.size() == 128);
    pulse_start();
    for (int i = 0; i < ea.size(); i++) send_word(ed[i], mode);
    @(negedge Clk);
    In_Valid = 1'b0;
    @(negedge Clk);
    check_writes(tag);
    chk({tag, "_done"}, 32'(Done), 32'(exp_done));
    chk({tag, "_error"}, 32'(Error), 32'(exp_err));
    chk({tag, "_cpurst"}, 32'(CPU_Reset), 32'(exp_done));
    chk({tag, "_count"}, 32'(Count), 32'(ea.size()));
    chk({tag, "_ready"}, 32'(In_Ready), 32'(0));
  endtask

  initial begin
    // reset state, then idle without Start
    #12;
    chk("rst_state", 32'({In_Ready, IM_Wr, CPU_Reset, Done, Error}), 32'(0));
    chk("rst_addr", 32'(IM_Addr), 32'(0));
    chk("rst_data", 32'(IM_Data), 32'(0));
    chk("rst_count", 32'(Count), 32'(0));
    #11 Reset = 1'b1;
    In_Valid = 1'b1;
    repeat (10) @(negedge Clk);
    chk("idle_nwr", 32'(oa.size()), 32'(0));
    chk("idle_cpurst", 32'(CPU_Reset), 32'(0));
    chk("idle_count", 32'(Count), 32'(0));
    chk("idle_ready", 32'(In_Ready), 32'(0));
    In_Valid = 1'b0;

    // continuous stream: one write every 3 cycles
    words = '{16'h1234, 16'h5678, 16'h5000};
    run_load("basic", 0);
    if (oc.size() == 3) begin
      chk("basic_gap1", 32'(oc[1] - oc[0]), 32'(3));
      chk("basic_gap2", 32'(oc[2] - oc[1]), 32'(3));
    end else chk("basic_gapcnt", 32'(oc.size()), 32'(3));

    // toggling valid
    words = '{16'hA00F, 16'h5000};
    run_load("toggle", 1);

    // 128 words, no halt
    words.delete();
    for (int i = 1; i <= 128; i++) words.push_back(16'(i));
    run_load("full", 0);
    @(negedge Clk);
    In_Valid = 1'b1;
    In_Data = 8'h50;
    repeat (10) @(negedge Clk);
    In_Valid = 1'b0;
    chk("full_no129", 32'(oa.size()), 32'(128));
    chk("full_err_hold", 32'(Error), 32'(1));

    // reset asserted in LO after high byte 0x50
    pulse_start();
    send_byte(8'h50, 0);
    @(negedge Clk);
    In_Valid = 1'b1;
    In_Data = 8'h00;
    #2 Reset = 1'b0;
    #1;
    chk("midrst_state", 32'({In_Ready, IM_Wr, Error, CPU_Reset}), 32'(0));
    chk("midrst_count", 32'(Count), 32'(0));
    #10 Reset = 1'b1;
    repeat (5) @(negedge Clk);
    chk("midrst_nwr", 32'(oa.size()), 32'(0));
    chk("midrst_idle", 32'(In_Ready), 32'(0));
    In_Valid = 1'b0;
    words = '{16'h5000};
    run_load("after_rst", 0);

    // restart from DONE, Start during LO ignored
    pulse_start();
    chk("restart_cpurst", 32'(CPU_Reset), 32'(0));
    chk("restart_count", 32'(Count), 32'(0));
    send_byte(8'h12, 0);
    @(negedge Clk);
    In_Valid = 1'b0;
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    send_byte(8'h34, 0);
    send_word(16'h5000, 0);
    @(negedge Clk);
    In_Valid = 1'b0;
    @(negedge Clk);
    ea = '{7'd0, 7'd1};
    ed = '{16'h1234, 16'h5000};
    check_writes("lo_start");
    chk("lo_start_done", 32'(Done), 32'(1));

    // randomized loads
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 12);
      words.delete();
      for (int i = 0; i < n; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if (w == 16'h5000) w = 16'h5001;
        words.push_back(w);
      end
      words[$urandom_range(0, n - 1)] = 16'h5000;
      run_load("rand", (r % 3 == 0) ? 1 : 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
